// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/funct constants and one-hot op-select encoding for the ALU
package alu_pkg;

  // Opcodes
  localparam logic [5:0] INST_R       = 6'h00;
  localparam logic [5:0] INST_J_J     = 6'h02;
  localparam logic [5:0] INST_I_BEQ   = 6'h04;
  localparam logic [5:0] INST_I_BNE   = 6'h05;
  localparam logic [5:0] INST_I_ADDI  = 6'h08;
  localparam logic [5:0] INST_I_ADDIU = 6'h09;
  localparam logic [5:0] INST_I_SLTI  = 6'h0A;
  localparam logic [5:0] INST_I_SLTIU = 6'h0B;
  localparam logic [5:0] INST_I_ANDI  = 6'h0C;
  localparam logic [5:0] INST_I_ORI   = 6'h0D;
  localparam logic [5:0] INST_I_XORI  = 6'h0E;
  localparam logic [5:0] INST_I_LUI   = 6'h0F;
  localparam logic [5:0] INST_I_LW    = 6'h23;
  localparam logic [5:0] INST_I_SW    = 6'h2B;

  // R-type functs
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // One-hot op select; OP_ZERO is the "result 0" op loaded at reset
  typedef enum logic [12:0] {
    OP_ZERO = 13'b0_0000_0000_0001,
    OP_ADD  = 13'b0_0000_0000_0010,
    OP_SUB  = 13'b0_0000_0000_0100,
    OP_AND  = 13'b0_0000_0000_1000,
    OP_OR   = 13'b0_0000_0001_0000,
    OP_XOR  = 13'b0_0000_0010_0000,
    OP_NOR  = 13'b0_0000_0100_0000,
    OP_SLT  = 13'b0_0000_1000_0000,
    OP_SLTU = 13'b0_0001_0000_0000,
    OP_SLL  = 13'b0_0010_0000_0000,
    OP_SRL  = 13'b0_0100_0000_0000,
    OP_SRA  = 13'b0_1000_0000_0000,
    OP_LUI  = 13'b1_0000_0000_0000
  } op_sel_t;

endpackage

// File: rtl/alu_predecode.sv
// rtl/alu_predecode.sv - registered opcode/funct to one-hot op decode; shifts gated by ALU_SHIFT_EN
module alu_predecode
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic [5:0] opcode_fwd,
  input  logic [5:0] funct_fwd,
  output op_sel_t  op_q
);

  op_sel_t op_d;

  // Map the ID-stage instruction to its op; anything unrecognised yields zero
  always_comb begin
    op_d = OP_ZERO;
    if (opcode_fwd == INST_R) begin
      case (funct_fwd)
        FUNCT_ADD, FUNCT_ADDU: op_d = OP_ADD;
        FUNCT_SUB, FUNCT_SUBU: op_d = OP_SUB;
        FUNCT_AND:             op_d = OP_AND;
        FUNCT_OR:              op_d = OP_OR;
        FUNCT_XOR:             op_d = OP_XOR;
        FUNCT_NOR:             op_d = OP_NOR;
        FUNCT_SLT:             op_d = OP_SLT;
        FUNCT_SLTU:            op_d = OP_SLTU;
`ifdef ALU_SHIFT_EN
        FUNCT_SLL, FUNCT_SLLV: op_d = OP_SLL;
        FUNCT_SRL, FUNCT_SRLV: op_d = OP_SRL;
        FUNCT_SRA, FUNCT_SRAV: op_d = OP_SRA;
`else
        FUNCT_SLL, FUNCT_SLLV,
        FUNCT_SRL, FUNCT_SRLV,
        FUNCT_SRA, FUNCT_SRAV: op_d = OP_ZERO;
`endif
        default:               op_d = OP_ZERO;
      endcase
    end else begin
      case (opcode_fwd)
        INST_I_ADDI, INST_I_ADDIU,
        INST_I_LW, INST_I_SW:           op_d = OP_ADD;
        INST_I_SLTI:                    op_d = OP_SLT;
        INST_I_SLTIU:                   op_d = OP_SLTU;
        INST_I_ANDI:                    op_d = OP_AND;
        INST_I_ORI:                     op_d = OP_OR;
        INST_I_XORI:                    op_d = OP_XOR;
        INST_I_LUI:                     op_d = OP_LUI;
        INST_I_BEQ, INST_I_BNE, INST_J_J: op_d = OP_ZERO;
        default:                        op_d = OP_ZERO;
      endcase
    end
  end

  // Decode register; reset selects the zero-result op
  always_ff @(posedge clk) begin
    if (rst) op_q <= OP_ZERO;
    else     op_q <= op_d;
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle registered integer ALU; shifter present only with ALU_SHIFT_EN
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode_fwd,
  input  logic [5:0]  funct_fwd,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rrs,
  input  logic [31:0] rrt_in,
  input  logic [15:0] imm,
  input  logic [4:0]  shamt_in,
  output logic [31:0] rslt
);

  op_sel_t     op_q;
  logic        is_r;
  logic [31:0] simm;
  logic [31:0] zimm;
  logic [31:0] b_arith;
  logic [31:0] b_logic;
  logic [31:0] rslt_d;
  logic [31:0] rslt_q;

  alu_predecode u_predecode (
    .clk        (clk),
    .rst        (rst),
    .opcode_fwd (opcode_fwd),
    .funct_fwd  (funct_fwd),
    .op_q       (op_q)
  );

`ifdef ALU_SHIFT_EN
  // Variable shifts (funct bit 2 set) take the amount from rs
  logic [4:0] sh_amt;
  logic       unused_funct;
  assign sh_amt       = funct[2] ? rrs[4:0] : shamt_in;
  assign unused_funct = ^{funct[5:3], funct[1:0]};
`else
  logic unused_shift;
  assign unused_shift = ^{funct, shamt_in};
`endif

  // Result mux: opcode only chooses register vs immediate second operand
  always_comb begin
    is_r    = (opcode == INST_R);
    simm    = {{16{imm[15]}}, imm};
    zimm    = {16'h0000, imm};
    b_arith = is_r ? rrt_in : simm;
    b_logic = is_r ? rrt_in : zimm;
    rslt_d  = '0;
    case (op_q)
      OP_ADD:  rslt_d = rrs + b_arith;
      OP_SUB:  rslt_d = rrs - rrt_in;
      OP_AND:  rslt_d = rrs & b_logic;
      OP_OR:   rslt_d = rrs | b_logic;
      OP_XOR:  rslt_d = rrs ^ b_logic;
      OP_NOR:  rslt_d = ~(rrs | rrt_in);
      OP_SLT:  rslt_d = {31'b0, $signed(rrs) < $signed(b_arith)};
      OP_SLTU: rslt_d = {31'b0, rrs < b_arith};
      OP_LUI:  rslt_d = {imm, 16'h0000};
`ifdef ALU_SHIFT_EN
      OP_SLL:  rslt_d = rrt_in << sh_amt;
      OP_SRL:  rslt_d = rrt_in >> sh_amt;
      OP_SRA:  rslt_d = $unsigned($signed(rrt_in) >>> sh_amt);
`else
      OP_SLL, OP_SRL, OP_SRA: rslt_d = '0;
`endif
      default: rslt_d = '0;
    endcase
  end

  // Result register feeding MM
  always_ff @(posedge clk) begin
    if (rst) rslt_q <= '0;
    else     rslt_q <= rslt_d;
  end

  assign rslt = rslt_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized and directed self-checking bench for alu against a behavioural model
module tb_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode_fwd = 6'h04;
  logic [5:0]  funct_fwd = 6'h00;
  logic [5:0]  opcode = 6'h04;
  logic [5:0]  funct = 6'h00;
  logic [31:0] rrs = '0;
  logic [31:0] rrt_in = '0;
  logic [15:0] imm = '0;
  logic [4:0]  shamt_in = '0;
  logic [31:0] rslt;

  int total = 0;
  int bad = 0;

  alu dut (
    .clk        (clk),
    .rst        (rst),
    .opcode_fwd (opcode_fwd),
    .funct_fwd  (funct_fwd),
    .opcode     (opcode),
    .funct      (funct),
    .rrs        (rrs),
    .rrt_in     (rrt_in),
    .imm        (imm),
    .shamt_in   (shamt_in),
    .rslt       (rslt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] im;
    logic [4:0]  sh;
    logic        r;
    logic        fwd_rs;
    logic        fwd_rt;
    logic        lit_en;
    logic [31:0] lit;
    string       name;
  } instr_t;

  instr_t prog[$];

  // Shift helpers built from single-bit steps
  function automatic logic [31:0] shl(input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) v = {v[30:0], 1'b0};
    return v;
  endfunction
  function automatic logic [31:0] shr(input logic [31:0] v, input int n, input logic ar);
    for (int k = 0; k < n; k++) v = {ar ? v[31] : 1'b0, v[31:1]};
    return v;
  endfunction

  // Reference semantics of one instruction
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] im, input logic [4:0] sh);
    logic [31:0] se;
    logic [31:0] ze;
    longint sa, sb, ss;
    se = {{16{im[15]}}, im};
    ze = {16'h0, im};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ss = longint'($signed(se));
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: return ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
        6'h00: return shl(b, int'(sh));
        6'h02: return shr(b, int'(sh), 1'b0);
        6'h03: return shr(b, int'(sh), 1'b1);
        6'h04: return shl(b, int'(a % 32));
        6'h06: return shr(b, int'(a % 32), 1'b0);
        6'h07: return shr(b, int'(a % 32), 1'b1);
`endif
        default: return 32'd0;
      endcase
    end
    case (op)
      6'h08, 6'h09, 6'h23, 6'h2B: return a + se;
      6'h0A: return (sa < ss) ? 32'd1 : 32'd0;
      6'h0B: return (a < se) ? 32'd1 : 32'd0;
      6'h0C: return a & ze;
      6'h0D: return a | ze;
      6'h0E: return a ^ ze;
      6'h0F: return {im, 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] shift_lit(input logic [31:0] v);
`ifdef ALU_SHIFT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [15:0] im, input logic [4:0] sh,
                     input logic r, input logic lit_en, input logic [31:0] lit, input string name);
    instr_t t;
    t.op = op; t.fn = fn; t.rs = rs; t.rt = rt; t.im = im; t.sh = sh; t.r = r;
    t.fwd_rs = 1'b0; t.fwd_rt = 1'b0; t.lit_en = lit_en; t.lit = lit; t.name = name;
    prog.push_back(t);
  endtask

  // Compare process: expectation formed at the edge, checked at the following negedge
  logic        rst_prev = 1'b1;
  logic        chk_q = 1'b0;
  logic [31:0] exp_q = '0;
  logic        lit_en_drv = 1'b0;
  logic [31:0] lit_drv = '0;
  string       lit_name_drv = "";
  logic        lit_en_q = 1'b0;
  logic [31:0] lit_q = '0;
  string       lit_name_q = "";

  always @(posedge clk) begin
    exp_q      <= (rst || rst_prev) ? 32'd0 : ref_alu(opcode, funct, rrs, rrt_in, imm, shamt_in);
    rst_prev   <= rst;
    chk_q      <= 1'b1;
    lit_en_q   <= lit_en_drv;
    lit_q      <= lit_drv;
    lit_name_q <= lit_name_drv;
  end

  always @(negedge clk) begin
    if (chk_q) begin
      total++;
      if (rslt !== exp_q) begin
        bad++;
        $display("FAIL model t=%0t rslt=%h expected=%h", $time, rslt, exp_q);
      end
      if (lit_en_q) begin
        total++;
        if (rslt !== lit_q) begin
          bad++;
          $display("FAIL %s rslt=%h expected=%h", lit_name_q, rslt, lit_q);
        end
      end
    end
  end

  logic [5:0] r_functs [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] i_ops [15] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                             6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h00};

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    instr_t t;
    int n;
    // Reset state and first-instruction bubble
    add(6'h04, 6'h00, 0, 0, 0, 0, 1'b1, 1'b0, 0, "");
    add(6'h04, 6'h00, 0, 0, 0, 0, 1'b1, 1'b1, 0, "reset_state");
    add(6'h04, 6'h00, 0, 0, 0, 0, 1'b0, 1'b1, 0, "post_reset_bubble");
    // Directed cases with hand-computed results
    add(6'h00, 6'h21, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 1, 32'h80000000, "addu_wrap");
    add(6'h00, 6'h23, 32'h0, 32'h1, 0, 0, 0, 1, 32'hFFFFFFFF, "subu_borrow");
    add(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 1, 32'h1, "slt_signed");
    add(6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 1, 32'h0, "sltu_unsigned");
    add(6'h0B, 6'h00, 32'h5, 32'h0, 16'hFFFF, 0, 0, 1, 32'h1, "sltiu_simm");
    add(6'h00, 6'h03, 32'h0, 32'h80000000, 0, 5'd4, 0, 1, shift_lit(32'hF8000000), "sra");
    add(6'h00, 6'h02, 32'h0, 32'h80000000, 0, 5'd4, 0, 1, shift_lit(32'h08000000), "srl");
    add(6'h00, 6'h04, 32'd33, 32'h80000000, 0, 5'd4, 0, 1, 32'h0, "sllv_mod32");
    add(6'h00, 6'h04, 32'd33, 32'h00000003, 0, 5'd4, 0, 1, shift_lit(32'h6), "sllv_amt1");
    add(6'h0F, 6'h00, 32'h0, 32'h0, 16'h1234, 0, 0, 1, 32'h12340000, "lui");
    add(6'h0D, 6'h00, 32'hFFFF0000, 32'h0, 16'h8001, 0, 0, 1, 32'hFFFF8001, "ori_zimm");
    add(6'h23, 6'h00, 32'h100, 32'h0, 16'hFFFC, 0, 0, 1, 32'h000000FC, "lw_addr");
    // Back-to-back forwarding
    add(6'h08, 6'h00, 32'h0, 32'h0, 16'h0005, 0, 0, 1, 32'h5, "addi_fwd_src");
    add(6'h00, 6'h20, 32'h0, 32'h0, 0, 0, 0, 1, 32'hA, "add_fwd_dst");
    prog[$].fwd_rs = 1'b1;
    prog[$].fwd_rt = 1'b1;
    // Reset in the middle of an ADD
    add(6'h00, 6'h20, 32'h3, 32'h4, 0, 0, 1, 1, 32'h0, "reset_during_add");
    add(6'h04, 6'h00, 32'h3, 32'h4, 0, 0, 0, 1, 32'h0, "bubble_after_reset");
    add(6'h04, 6'h00, 32'h3, 32'h3, 0, 0, 0, 1, 32'h0, "beq_zero");
    add(6'h3F, 6'h00, 32'h12345678, 32'h9, 16'h1111, 0, 0, 1, 32'h0, "unknown_op");
    add(6'h00, 6'h3F, 32'h12345678, 32'h9, 16'h1111, 0, 0, 1, 32'h0, "unknown_funct");
    // Randomized traffic with occasional resets and forwarding
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0)
        add(6'h00, r_functs[$urandom_range(0, 15)], rand_word(), rand_word(),
            16'($urandom), 5'($urandom), ($urandom_range(0, 49) == 0), 0, 0, "");
      else
        add(i_ops[$urandom_range(0, 14)], 6'($urandom), rand_word(), rand_word(),
            16'($urandom), 5'($urandom), ($urandom_range(0, 49) == 0), 0, 0, "");
      prog[$].fwd_rs = ($urandom_range(0, 7) == 0);
      prog[$].fwd_rt = ($urandom_range(0, 7) == 0);
    end
    add(6'h04, 6'h00, 0, 0, 0, 0, 0, 0, 0, "");

    // Driver: inputs change 3 time units after each rising edge
    n = prog.size();
    @(posedge clk);
    #3;
    for (int i = 0; i < n; i++) begin
      t = prog[i];
      rst      = t.r;
      opcode   = t.op;
      funct    = t.fn;
      rrs      = t.fwd_rs ? rslt : t.rs;
      rrt_in   = t.fwd_rt ? rslt : t.rt;
      imm      = t.im;
      shamt_in = t.sh;
      if (i + 1 < n) begin
        opcode_fwd = prog[i + 1].op;
        funct_fwd  = prog[i + 1].fn;
      end else begin
        opcode_fwd = 6'h04;
        funct_fwd  = 6'h00;
      end
      lit_en_drv   = t.lit_en;
      lit_drv      = t.lit;
      lit_name_drv = t.name;
      @(posedge clk);
      #3;
    end
    lit_en_drv = 1'b0;
    repeat (3) @(posedge clk);
    #7;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Single-cycle-latency integer ALU for the five-stage MIPS pipeline, sitting between the EX and MM stages. It pre-decodes the instruction while it is still in ID, using the `_fwd` ports. It then computes the result from the forwarded EX operands and registers it, so the result is valid during MM. In MM the result serves as the data-memory address, as the forwarding source and as the write-back value.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `opcode_fwd` in 6: opcode of the instruction currently in ID.
- `funct_fwd` in 6: funct of the instruction currently in ID.
- `opcode` in 6: opcode of the instruction currently in EX.
- `funct` in 6: funct of the instruction currently in EX.
- `rrs` in 32: rs operand, already forwarded.
- `rrt_in` in 32: rt operand, already forwarded.
- `imm` in 16: I-format immediate.
- `shamt_in` in 5: shift amount field.
- `rslt` out 32: registered result.

## Operation
- **Pre-decode.** At each edge, `opcode_fwd`/`funct_fwd` are decoded into a registered one-hot op select. The pipeline never stalls, so `opcode`/`funct` at the next cycle always equal the captured `_fwd` values.
- **Op selection.** The op select chooses the function. `opcode`/`funct` only qualify the decode (R vs. I).
- **Immediates.** `simm` = sign-extension of `imm`. `zimm` = zero-extension of `imm`.
- **R-type (opcode 0x00), selected by funct:**
  - ADD 0x20 and ADDU 0x21: rs + rt. Neither traps on overflow.
  - SUB 0x22 and SUBU 0x23: rs − rt.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLT 0x2A: signed compare. SLTU 0x2B: unsigned compare. Result is 1 or 0.
  - SLL 0x00, SRL 0x02, SRA 0x03: shift rt by `shamt_in`.
  - SLLV 0x04, SRLV 0x06, SRAV 0x07: shift rt by `rrs[4:0]`.
- **I-type, selected by opcode:**
  - ADDI 0x08 and ADDIU 0x09: rs + simm.
  - SLTI 0x0A: signed compare with simm. SLTIU 0x0B: unsigned compare with simm.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: bitwise with zimm.
  - LUI 0x0F: {imm, 16'h0}.
  - LW 0x23 and SW 0x2B: rs + simm (word address generation).
- **Everything else** (BEQ 0x04, BNE 0x05, J 0x02, unknown opcode or funct): result 0.
- **Arithmetic.** All arithmetic is modulo 2^32. Shift amounts are 0..31. SRA/SRAV replicate bit 31.

## Timing
- Decode register is loaded at edge T from the `_fwd` ports (instruction in ID).
- `rslt` is loaded at edge T+1 from the EX ports and operands. Latency is 1 cycle from operands to `rslt`.
- A new operation is accepted every cycle, with no handshake.
- `rslt` may be fed back into `rrs`/`rrt_in` the next cycle (back-to-back forwarding). There must be no combinational path from `rslt` to itself.
- **Reset:**
  - `rst` high at an edge forces `rslt` to 0 and the decode register to the "result 0" op.
  - An instruction in EX during a reset cycle therefore produces 0.
  - The first instruction after reset deasserts needs one prior edge of pre-decode; the pipeline delivers it to ID at least one cycle before EX.

## Configuration
- Macro: `ALU_SHIFT_EN`.
- Defined: the six shift operations behave as specified.
- Undefined: the shifter is removed and all six shift functs produce 0.

## Structure
- A shared package holds the opcode constants (`INST_R`, `INST_I_*`, `INST_J_J`), the funct constants (`FUNCT_*`) and the one-hot op-select encoding.
- One sub-module is natural: `alu_predecode`. It maps opcode and funct to the registered op select and carries its own reset.

## Test plan
- ADDU, rs=0x7FFFFFFF, rt=1 → `rslt`=0x80000000 one cycle later. SUBU, rs=0, rt=1 → 0xFFFFFFFF.
- SLT, rs=0xFFFFFFFF, rt=1 → 1. SLTU with the same operands → 0. SLTIU, rs=5, imm=0xFFFF → 1.
- Shifts, rt=0x80000000, shamt=4:
  - SRA → 0xF8000000.
  - SRL → 0x08000000.
  - SLLV with rs=33 → 0x00000000, since shift amount = 1.
- LUI, imm=0x1234 → 0x12340000. ORI, rs=0xFFFF0000, imm=0x8001 → 0xFFFF8001. LW, rs=0x100, imm=0xFFFC → 0xFC.
- Back-to-back: ADDI $1=$0+5 then ADD $2=$1+$1, with `rslt` fed back → 5 then 10 on consecutive cycles.
- Assert `rst` during an ADD in EX → `rslt`=0 next cycle. BEQ or unknown opcode 0x3F → 0.
